// File: rtl/scan_edge_pkg.sv
// Shared defaults, FSM state and event record for the scan-line edge detector.
package scan_edge_pkg;

  localparam int unsigned PIX_W_D    = 8;
  localparam int unsigned IDX_W_D    = 15;
  localparam int unsigned LINE_LEN_D = 150;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W_D-1:0] idx;
    logic [PIX_W_D-1:0] mag;
    logic               pol;
  } edge_evt_t;

endpackage

// File: rtl/scan_edge_fifo.sv
// Show-ahead synchronous FIFO of edge events; a push into a full FIFO without a
// simultaneous pop is dropped and flagged for one cycle on drop.
module scan_edge_fifo
  import scan_edge_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         evt_t = edge_evt_t
) (
  input  logic clk,
  input  logic resetN,
  input  logic push,
  input  evt_t din,
  input  logic pop,
  output evt_t dout,
  output logic full,
  output logic empty,
  output logic drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr, rd_ptr;
  evt_t        mem [DEPTH];
  logic        do_pop, do_push;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;
    dout    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/scan_edge_detector.sv
// Per-scan-line adjacent-pixel edge detector feeding an event FIFO.
// Optional SCAN_EDGE_COUNT_EN adds line_done / line_edges per-line reporting.
module scan_edge_detector
  import scan_edge_pkg::*;
#(
  parameter int unsigned PIX_W      = PIX_W_D,
  parameter int unsigned IDX_W      = IDX_W_D,
  parameter int unsigned LINE_LEN   = LINE_LEN_D,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enb,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [IDX_W-1:0] pix_idx,
  input  logic             line_rst,
  input  logic [PIX_W-1:0] threshold,
  output logic             edge_valid,
  input  logic             edge_ready,
  output logic [IDX_W-1:0] edge_idx,
  output logic [PIX_W-1:0] edge_mag,
  output logic             edge_pol,
  output logic             overflow,
  output logic             line_err
`ifdef SCAN_EDGE_COUNT_EN
  ,
  output logic             line_done,
  output logic [7:0]       line_edges
`endif
);

  localparam int unsigned CNT_W = $clog2(LINE_LEN + 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [PIX_W-1:0] mag;
    logic             pol;
  } evt_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] prev_q, thr_q, mag_c;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, start, step, at_limit, len_err, pol_c, hit;
  logic             s1_hit;
  evt_t             s1_evt, head;
  logic             fifo_full, fifo_empty, fifo_drop;

  always_comb begin
    accept   = enb & pix_valid;
    at_limit = (cnt_q == CNT_W'(LINE_LEN));
    // IDLE and an exhausted line both fall back to starting a new line
    start    = accept & (line_rst | (state_q != TRACK) | at_limit);
    step     = accept & ~start;
    len_err  = accept & ~line_rst & (state_q == TRACK) & at_limit;
    pol_c    = (pix_data > prev_q);
    mag_c    = pol_c ? (pix_data - prev_q) : (prev_q - pix_data);
    hit      = step & (mag_c > thr_q);

    state_d = state_q;
    if (!enb)
      state_d = IDLE;
    else if (accept)
      state_d = TRACK;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      cnt_q    <= '0;
      thr_q    <= '0;
      line_err <= 1'b0;
      overflow <= 1'b0;
      s1_hit   <= 1'b0;
      s1_evt   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        prev_q <= pix_data;
        cnt_q  <= CNT_W'(1);
        thr_q  <= threshold;
      end else if (step) begin
        prev_q <= pix_data;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (len_err)
        line_err <= 1'b1;
      if (fifo_drop)
        overflow <= 1'b1;
      s1_hit <= hit;
      s1_evt <= '{idx: pix_idx, mag: mag_c, pol: pol_c};
    end
  end

  scan_edge_fifo #(
    .DEPTH (FIFO_DEPTH),
    .evt_t (evt_t)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (s1_hit),
    .din    (s1_evt),
    .pop    (edge_ready),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

  always_comb begin
    edge_valid = ~fifo_empty;
    edge_idx   = head.idx;
    edge_mag   = head.mag;
    edge_pol   = head.pol;
  end

  a_drop_only_when_full: assert property (@(posedge clk) disable iff (!resetN)
    fifo_drop |-> fifo_full);

`ifdef SCAN_EDGE_COUNT_EN
  logic [7:0] lcnt_q, lcnt_inc, edges_c, s1_edges;
  logic       end_len, end_prev, s1_done;

  // A line ends on its last allowed pixel, or retroactively when a new line
  // starts while an unfinished one is still counted (cnt 1..LINE_LEN-1).
  always_comb begin
    lcnt_inc = (hit && (lcnt_q != 8'hFF)) ? lcnt_q + 8'd1 : lcnt_q;
    end_len  = step & (cnt_q == CNT_W'(LINE_LEN - 1));
    end_prev = start & (cnt_q != '0) & ~at_limit;
    edges_c  = end_len ? lcnt_inc : lcnt_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lcnt_q     <= '0;
      s1_done    <= 1'b0;
      s1_edges   <= '0;
      line_done  <= 1'b0;
      line_edges <= '0;
    end else begin
      if (start)
        lcnt_q <= '0;
      else if (step)
        lcnt_q <= lcnt_inc;
      s1_done   <= end_len | end_prev;
      s1_edges  <= edges_c;
      line_done <= s1_done;
      if (s1_done)
        line_edges <= s1_edges;
    end
  end
`endif

endmodule

// File: tb/tb_scan_edge_detector.sv
// Directed bench for scan_edge_detector; define SCAN_EDGE_COUNT_EN to also
// exercise line_done / line_edges.
module tb_scan_edge_detector;

  logic        clk = 1'b0;
  logic        resetN, enb, pix_valid, line_rst, edge_ready;
  logic [7:0]  pix_data, threshold;
  logic [14:0] pix_idx;
  logic        edge_valid, edge_pol, overflow, line_err;
  logic [14:0] edge_idx;
  logic [7:0]  edge_mag;
  int          n_chk = 0;
  int          n_bad = 0;
`ifdef SCAN_EDGE_COUNT_EN
  logic        line_done;
  logic [7:0]  line_edges;
  int          done_cnt = 0;
  int          last_edges = -1;
`endif

  always #5 clk = ~clk;

  scan_edge_detector #(
    .PIX_W      (8),
    .IDX_W      (15),
    .LINE_LEN   (150),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .enb        (enb),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_idx    (pix_idx),
    .line_rst   (line_rst),
    .threshold  (threshold),
    .edge_valid (edge_valid),
    .edge_ready (edge_ready),
    .edge_idx   (edge_idx),
    .edge_mag   (edge_mag),
    .edge_pol   (edge_pol),
    .overflow   (overflow),
    .line_err   (line_err)
`ifdef SCAN_EDGE_COUNT_EN
    ,
    .line_done  (line_done),
    .line_edges (line_edges)
`endif
  );

`ifdef SCAN_EDGE_COUNT_EN
  always @(negedge clk) begin
    if (line_done) begin
      done_cnt   = done_cnt + 1;
      last_edges = int'(line_edges);
    end
  end
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic px(input int d, input int i, input bit lr);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = 8'(d);
    pix_idx   = 15'(i);
    line_rst  = lr;
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    pix_valid = 1'b0;
    line_rst  = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input int idx, input int mag, input int pol);
    int n = 0;
    while (!edge_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, int'(edge_valid), 1);
    chk({tag, "_idx"}, int'(edge_idx), idx);
    chk({tag, "_mag"}, int'(edge_mag), mag);
    chk({tag, "_pol"}, int'(edge_pol), pol);
    edge_ready = 1'b1;
    @(negedge clk);
    edge_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; enb = 1'b1; pix_valid = 1'b0; line_rst = 1'b0;
    edge_ready = 1'b0; pix_data = '0; threshold = '0; pix_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(edge_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_lerr", int'(line_err), 0);
    chk("rst_idx", int'(edge_idx), 0);
    chk("rst_mag", int'(edge_mag), 0);
    chk("rst_pol", int'(edge_pol), 0);
    resetN = 1'b1;

    // basic step, with latency check on the first event
    threshold = 8'd10;
    px(5, 0, 1);
    px(5, 1, 0);
    px(30, 2, 0);
    px(30, 3, 0);
    chk("lat_n1", int'(edge_valid), 0);
    px(12, 4, 0);
    chk("lat_n2", int'(edge_valid), 1);
    gap(3);
    pop_chk("basic0", 2, 25, 1);
    pop_chk("basic1", 4, 18, 0);
    chk("basic_empty", int'(edge_valid), 0);

    // threshold boundary and mid-line threshold change
    threshold = 8'd20;
    px(100, 10, 1);
    px(120, 11, 0);
    px(141, 12, 0);
    threshold = 8'd0;
    px(146, 13, 0);
    px(146, 14, 1);
    px(147, 15, 0);
    gap(3);
    pop_chk("thr0", 12, 21, 1);
    pop_chk("thr1", 15, 1, 1);
    chk("thr_empty", int'(edge_valid), 0);
    chk("thr_ovf", int'(overflow), 0);

    // backpressure: six events into four slots
    threshold = 8'd10;
    px(0, 20, 1);
    for (int k = 0; k < 6; k++)
      px((k % 2 == 0) ? 50 : 0, 21 + k, 0);
    gap(4);
    chk("bp_ovf", int'(overflow), 1);
    pop_chk("bp0", 21, 50, 1);
    pop_chk("bp1", 22, 50, 0);
    pop_chk("bp2", 23, 50, 1);
    pop_chk("bp3", 24, 50, 0);
    chk("bp_empty", int'(edge_valid), 0);
    chk("bp_ovf_sticky", int'(overflow), 1);

    // line length: 150 pixels are fine, the 151st forces a new line
    threshold = 8'd0;
    px(7, 100, 1);
    for (int k = 1; k < 150; k++)
      px(7, 100 + k, 0);
    gap(2);
    chk("len_ok", int'(line_err), 0);
    px(200, 250, 0);
    gap(3);
    chk("len_err", int'(line_err), 1);
    chk("len_noevt", int'(edge_valid), 0);
    px(203, 251, 0);
    gap(3);
    pop_chk("len_new", 251, 3, 1);

    // reset mid-line with two events queued
    threshold = 8'd10;
    px(0, 30, 1);
    px(40, 31, 0);
    px(0, 32, 0);
    gap(3);
    chk("rm_queued", int'(edge_valid), 1);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("rm_valid", int'(edge_valid), 0);
    chk("rm_ovf", int'(overflow), 0);
    chk("rm_lerr", int'(line_err), 0);
    @(negedge clk);
    resetN = 1'b1;
    px(0, 40, 1);
    px(20, 41, 0);
    gap(3);
    pop_chk("rm_fresh", 41, 20, 1);
    chk("rm_empty", int'(edge_valid), 0);

    // enable dropped for one cycle mid-line
    px(0, 50, 1);
    px(20, 51, 0);
    @(negedge clk);
    enb = 1'b0; pix_data = 8'd99; pix_idx = 15'd52;
    px(60, 53, 0);
    enb = 1'b1;
    px(61, 54, 0);
    px(90, 55, 0);
    gap(3);
    pop_chk("enb0", 51, 20, 1);
    pop_chk("enb1", 55, 29, 1);
    chk("enb_empty", int'(edge_valid), 0);

`ifdef SCAN_EDGE_COUNT_EN
    begin
      int d0;
      edge_ready = 1'b1;
      threshold  = 8'd10;
      px(0, 0, 1);
      gap(3);
      d0 = done_cnt;
      for (int k = 1; k < 150; k++)
        px(((k >= 10 && k < 20) || k >= 30) ? 50 : 0, k, 0);
      gap(5);
      chk("cnt_done", done_cnt - d0, 1);
      chk("cnt_edges", last_edges, 3);
      edge_ready = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_edge_detector.md
# scan_edge_detector

Consumes the pixel stream produced by the image-memory read of the scan counter's index sequence, in any of the four scan modes (LR, UD, TTL, TTR). For each scan line it compares adjacent pixels and queues an edge event wherever the absolute step exceeds a threshold. The counter's line reset delimits lines. Events leave through a small FIFO with a valid/ready handshake toward the YODA feature stage.

## Interface
- `PIX_W`, 8: pixel width in bits.
- `IDX_W`, 15: pixel index width; 150² requires 15 bits.
- `LINE_LEN`, 150: maximum pixels per scan line.
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of two and at least 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `enb` in 1: block enable; when low, pixels are ignored.
- `pix_valid` in 1: `pix_data`, `pix_idx` and `line_rst` are valid this cycle. There is no backpressure on the input.
- `pix_data` in `PIX_W`: pixel value.
- `pix_idx` in `IDX_W`: linear index of the pixel (counter `cout` delayed by the RAM latency).
- `line_rst` in 1: this pixel is the first of a new line.
- `threshold` in `PIX_W`: edge threshold, unsigned.
- `edge_valid` out 1: FIFO head is valid.
- `edge_ready` in 1: consumer accepts the FIFO head.
- `edge_idx` out `IDX_W`: index of the second pixel of the step.
- `edge_mag` out `PIX_W`: |cur − prev|.
- `edge_pol` out 1: 1 = rising (cur > prev).
- `overflow` out 1: sticky; at least one event was dropped.
- `line_err` out 1: sticky; a line exceeded `LINE_LEN`.

## Operation
- A pixel is accepted when `enb & pix_valid`.
- FSM has two states:
  - `IDLE`: no previous pixel held.
  - `TRACK`: previous pixel held.
- Accepted pixel with `line_rst`:
  - store it as prev, set pixel count to 1, latch `threshold` into `thr_q`, go to `TRACK`;
  - no event is produced.
- Accepted pixel in `TRACK` without `line_rst`, while count < `LINE_LEN`:
  - compute `mag = |cur − prev|` at `PIX_W` bits without overflow (subtract larger minus smaller);
  - `pol = cur > prev`;
  - prev ← cur, count += 1;
  - raise an event if `mag > thr_q` (strict compare).
- Accepted pixel in `IDLE` without `line_rst`: treated as a line start with the current `threshold`; no event.
- Accepted pixel without `line_rst` when count == `LINE_LEN`:
  - set `line_err`;
  - treat the pixel as a line start.
- `threshold` changes take effect only at the next line start.
- `enb` low: FSM goes to `IDLE` on the next edge; pipeline contents and FIFO contents are kept; the FIFO keeps draining.
- FIFO:
  - Head is presented combinationally from storage (show-ahead).
  - A pop occurs on `edge_valid & edge_ready`.
  - A push into a full FIFO with a simultaneous pop is accepted.
  - A push into a full FIFO without a pop drops the event and sets `overflow`.
- `overflow` and `line_err` clear only on reset.
- Reset values:
  - all outputs 0, FIFO empty, FSM in `IDLE`, count 0, `thr_q` 0;
  - reset mid-line discards the line and all queued events.

## Timing
- Two-stage pipeline:
  - S1 registers `mag`, `pol`, `idx` and an event flag at the edge after acceptance (cycle N+1);
  - S2 writes the FIFO at N+2.
- With the FIFO empty, `edge_valid` is high from N+2 until popped.
- Throughput is one pixel per clock, sustained.
- `line_rst` on consecutive cycles is legal; each such pixel is a one-pixel line.

## Configuration
- `SCAN_EDGE_COUNT_EN` defined adds two outputs:
  - `line_done` out 1: one-cycle pulse at N+2 for the pixel that ends a line. A line ends at its `LINE_LEN`-th pixel, or at the pixel preceding a `line_rst` / forced line start.
  - `line_edges` out 8: number of events detected in that line, dropped events included, saturating at 255. Valid with `line_done`; reset value 0.
- Undefined: both ports and the per-line counter are absent; all other behaviour is identical.

## Structure
- Package `scan_edge_pkg` holds:
  - default `PIX_W`, `IDX_W`, `LINE_LEN`;
  - FSM state enum (`IDLE`, `TRACK`);
  - packed `edge_evt_t` struct {idx, mag, pol}.
- One sub-module, `scan_edge_fifo`: a parameterised synchronous FIFO of `edge_evt_t` with full/empty and a drop-on-full flag.

## Test plan
- Basic step: `threshold`=10, line 0..4 with `line_rst` on pixel 0 and data 5,5,30,30,12 → two events: (idx 2, mag 25, pol 1), then (idx 4, mag 18, pol 0). First `edge_valid` 2 cycles after pixel 2 is accepted.
- Threshold boundary: `threshold`=20, step of exactly 20 → no event. Step of 21 → event. `threshold` changed mid-line → old value used until the next `line_rst`.
- Backpressure: `edge_ready`=0, 6 successive qualifying steps, `FIFO_DEPTH`=4 → 4 events retained in order, `overflow`=1. Then `edge_ready`=1 → exactly 4 pops.
- Line length: 151 pixels without a second `line_rst` → `line_err`=1. Pixel 151 produces no event (treated as a line start).
- Reset and enable: `resetN` low mid-line with 2 events queued → `edge_valid`=0, `overflow`=0, next line behaves fresh. Also, `enb` low for 1 cycle mid-line → the next pixel produces no event.
- With `SCAN_EDGE_COUNT_EN`: 150-pixel line with 3 qualifying steps → single `line_done` pulse with `line_edges`=3.
